// File: rtl/mil1553_bus_sched_pkg.sv
// Shared types and elaboration helpers for the 1553 bus scheduler.
package mil1553_bus_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEAD, ST_XFER, ST_DRAIN, ST_RESP, ST_GAP
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

  // Down-counter load value for an N-cycle phase; 0-length phases still last one cycle.
  function automatic int ld_val(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/mil1553_bus_sched_if.sv
// Word stream (data, sync type, last) with valid/ready handshake.
interface mil1553_bus_sched_if;
  logic [15:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/mil1553_rr_arb.sv
// 2-way round-robin arbiter; pointer moves only when a message is retired.
module mil1553_rr_arb (
  input  logic       aclk,
  input  logic       arst,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic [1:0] served,
  output logic [1:0] gnt
);
  logic prio;  // 1: s1 wins a tie

  always_ff @(posedge aclk or posedge arst) begin
    if (arst)     prio <= 1'b0;
    else if (adv) prio <= served[0];
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/mil1553_bus_sched.sv
// Half-duplex 1553 scheduler: whole-message arbitration, en_tx lead/trail,
// response window and bus-idle gap before the next grant.
module mil1553_bus_sched
  import mil1553_bus_sched_pkg::*;
#(
  parameter int LEAD_CYCLES  = 2,
  parameter int TRAIL_CYCLES = 2,
  parameter int RESP_TIMEOUT = 28,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                 aclk,
  input  logic                 arst,
  mil1553_bus_sched_if.slave   s0,
  mil1553_bus_sched_if.slave   s1,
  mil1553_bus_sched_if.master  m,
  input  logic                 tx_busy,
  input  logic                 rx_busy,
  output logic                 en_tx,
  output logic [1:0]           grant,
  output logic                 resp_ok,
  output logic                 resp_tmo
);
  localparam int CW = cnt_w(max2(max2(LEAD_CYCLES, TRAIL_CYCLES),
                                 max2(RESP_TIMEOUT, GAP_CYCLES)));
  localparam logic [CW-1:0] LEAD_LD  = CW'(ld_val(LEAD_CYCLES));
  localparam logic [CW-1:0] TRAIL_LD = CW'(ld_val(TRAIL_CYCLES));
  localparam logic [CW-1:0] RESP_LD  = CW'(ld_val(RESP_TIMEOUT));
  localparam logic [CW-1:0] GAP_LD   = CW'(ld_val(GAP_CYCLES));

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    grant_nxt, arb_gnt;
  logic          ok_nxt, tmo_nxt, arb_adv;
  logic          xfer, sel_valid, sel_last;

  mil1553_rr_arb u_arb (
    .aclk   (aclk),
    .arst   (arst),
    .req    ({s1.tvalid, s0.tvalid}),
    .adv    (arb_adv),
    .served (grant),
    .gnt    (arb_gnt)
  );

  // Encoder port is a straight pass-through of the owner, gated to XFER.
  always_comb begin
    xfer      = (state == ST_XFER);
    sel_valid = grant[1] ? s1.tvalid : (grant[0] & s0.tvalid);
    sel_last  = grant[1] ? s1.tlast  : s0.tlast;
    m.tdata   = grant[1] ? s1.tdata  : s0.tdata;
    m.tuser   = grant[1] ? s1.tuser  : s0.tuser;
    m.tlast   = sel_last;
    m.tvalid  = xfer & sel_valid;
    s0.tready = xfer & grant[0] & m.tready;
    s1.tready = xfer & grant[1] & m.tready;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    ok_nxt    = 1'b0;
    tmo_nxt   = 1'b0;
    arb_adv   = 1'b0;
    case (state)
      ST_IDLE:
        if (!rx_busy && arb_gnt != 2'b00) begin
          grant_nxt = arb_gnt;
          state_nxt = (LEAD_CYCLES == 0) ? ST_XFER : ST_LEAD;
          cnt_nxt   = LEAD_LD;
        end
      ST_LEAD:
        if (cnt == '0) state_nxt = ST_XFER;
        else           cnt_nxt   = cnt - CW'(1);
      ST_XFER:
        if (sel_valid && m.tready && sel_last) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = TRAIL_LD;
        end
      ST_DRAIN:
        // Trail count only runs once the encoder has gone idle.
        if (tx_busy) cnt_nxt = TRAIL_LD;
        else if (cnt == '0) begin
          state_nxt = (RESP_TIMEOUT == 0) ? ST_GAP : ST_RESP;
          cnt_nxt   = (RESP_TIMEOUT == 0) ? GAP_LD : RESP_LD;
        end else cnt_nxt = cnt - CW'(1);
      ST_RESP:
        if (rx_busy || cnt == '0) begin
          ok_nxt    = rx_busy;
          tmo_nxt   = !rx_busy;
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LD;
        end else cnt_nxt = cnt - CW'(1);
      ST_GAP:
        if (rx_busy) cnt_nxt = GAP_LD;
        else if (cnt == '0) begin
          state_nxt = ST_IDLE;
          grant_nxt = 2'b00;
          arb_adv   = 1'b1;
        end else cnt_nxt = cnt - CW'(1);
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      grant    <= 2'b00;
      en_tx    <= 1'b0;
      resp_ok  <= 1'b0;
      resp_tmo <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      grant    <= grant_nxt;
      en_tx    <= (state_nxt == ST_LEAD) || (state_nxt == ST_XFER) || (state_nxt == ST_DRAIN);
      resp_ok  <= ok_nxt;
      resp_tmo <= tmo_nxt;
    end
  end
endmodule

// File: tb/tb_mil1553_bus_sched.sv
// Directed bench for mil1553_bus_sched: timing, arbitration, response window, gap, reset.
module tb_mil1553_bus_sched;
  logic       aclk = 1'b0;
  logic       arst = 1'b1;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       en_tx, resp_ok, resp_tmo;
  logic [1:0] grant;
  int         n_chk = 0;
  int         n_err = 0;
  logic [15:0] msg [4];

  mil1553_bus_sched_if s0_if();
  mil1553_bus_sched_if s1_if();
  mil1553_bus_sched_if m_if();

  mil1553_bus_sched dut (
    .aclk (aclk), .arst (arst),
    .s0 (s0_if), .s1 (s1_if), .m (m_if),
    .tx_busy (tx_busy), .rx_busy (rx_busy),
    .en_tx (en_tx), .grant (grant), .resp_ok (resp_ok), .resp_tmo (resp_tmo)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic put(input int src, input logic v, input logic [15:0] d, input logic l);
    if (src == 0) begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l; s0_if.tuser = 8'h30;
    end else begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l; s1_if.tuser = 8'h31;
    end
  endtask

  task automatic hs_word(input int src, input logic [15:0] d, input logic l, input string tag);
    int   n;
    logic hs;
    n = 0; hs = 1'b0;
    put(src, 1'b1, d, l);
    while (!hs && n < 50) begin
      #1;
      hs = (src == 0) ? s0_if.tready : s1_if.tready;
      if (hs) chk(tag, {16'h0, m_if.tdata}, {16'h0, d});
      step();
      n++;
    end
    if (!hs) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send(input int src, input int n, input string tag);
    for (int i = 0; i < n; i++) hs_word(src, msg[i], (i == n - 1), tag);
    put(src, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (grant != 2'b00 && n < 200) begin step(); n++; end
    chk(tag, grant, 2'b00);
  endtask

  task automatic wait_en_low(input string tag);
    int n;
    n = 0;
    while (en_tx && n < 50) begin step(); n++; end
    chk(tag, en_tx, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    m_if.tready = 1'b1;
    put(0, 1'b0, 16'h0, 1'b0);
    put(1, 1'b0, 16'h0, 1'b0);

    // reset state
    step();
    #1;
    chk("rst_en_tx", en_tx, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s0_tready", s0_if.tready, 0);
    chk("rst_s1_tready", s1_if.tready, 0);
    chk("rst_resp", {resp_ok, resp_tmo}, 0);
    step();
    arst = 1'b0;
    step();

    // tie right after reset: s0 first, s1 waits, then s1, then next tie to s0
    msg[0] = 16'h1111; msg[1] = 16'h2222;
    put(0, 1'b1, msg[0], 1'b0);
    put(1, 1'b1, 16'h5555, 1'b1);
    step();
    chk("t2_tie0", grant, 2'b01);
    send(0, 2, "t2_s0_word");
    chk("t2_s1_waits_grant", grant, 2'b01);
    n = 0;
    while (grant != 2'b10 && n < 100) begin step(); n++; end
    chk("t2_s1_second", grant, 2'b10);
    msg[0] = 16'h5555;
    send(1, 1, "t2_s1_word");
    wait_idle("t2_idle1");
    msg[0] = 16'h3333;
    put(0, 1'b1, msg[0], 1'b1);
    put(1, 1'b1, 16'h6666, 1'b1);
    step();
    chk("t2_tie_again", grant, 2'b01);
    put(1, 1'b0, 16'h0, 1'b0);
    send(0, 1, "t2_s0_again");
    wait_idle("t2_idle2");

    // 3-word message: lead, order, trail, timeout latency
    msg[0] = 16'h1234; msg[1] = 16'hABCD; msg[2] = 16'h0F0F;
    tx_busy = 1'b1;
    put(0, 1'b1, msg[0], 1'b0);
    step();
    chk("t1_en_up", en_tx, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_lead1_valid", m_if.tvalid, 0);
    step();
    chk("t1_lead2_valid", m_if.tvalid, 0);
    step();
    #1;
    chk("t1_first_valid", m_if.tvalid, 1);
    chk("t1_tuser", {24'h0, m_if.tuser}, 32'h30);
    send(0, 3, "t1_word");
    chk("t1_drain_en", en_tx, 1);
    chk("t1_drain_valid", m_if.tvalid, 0);
    step(); step();
    chk("t1_hold_busy", en_tx, 1);
    tx_busy = 1'b0;
    step();
    chk("t1_trail1", en_tx, 1);
    step();
    chk("t1_trail_end", en_tx, 0);
    n = 0;
    while (!resp_tmo && n < 60) begin step(); n++; end
    chk("t3_tmo_latency", n, 28);
    step();
    chk("t3_tmo_pulse", resp_tmo, 0);
    wait_idle("t1_idle");

    // response seen 5 cycles into window
    msg[0] = 16'h4444;
    send(0, 1, "t3_word");
    wait_en_low("t3_en_low");
    repeat (4) step();
    rx_busy = 1'b1;
    step();
    rx_busy = 1'b0;
    chk("t3_resp_ok", resp_ok, 1);
    chk("t3_no_tmo_now", resp_tmo, 0);
    step();
    chk("t3_ok_pulse", resp_ok, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_tmo) seen = 1'b1;
      step();
    end
    chk("t3_no_tmo", seen, 0);
    chk("t3_idle", grant, 0);

    // bus busy in IDLE blocks grant
    rx_busy = 1'b1;
    put(1, 1'b1, 16'h7777, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (grant != 2'b00 || en_tx) seen = 1'b1;
    end
    chk("t4_blocked", seen, 0);
    rx_busy = 1'b0;
    step();
    chk("t4_grant_after", grant, 2'b10);
    chk("t4_en_after", en_tx, 1);
    msg[0] = 16'h7777;
    send(1, 1, "t4_word");
    wait_idle("t4_idle");

    // gap restart on rx_busy glitch
    msg[0] = 16'h8888;
    send(0, 1, "t5_word");
    wait_en_low("t5_en_low");
    rx_busy = 1'b1;
    step();
    rx_busy = 1'b0;
    put(1, 1'b1, 16'h9999, 1'b1);
    repeat (6) step();
    rx_busy = 1'b1;
    step();
    rx_busy = 1'b0;
    chk("t5_grant_holds", grant, 2'b01);
    n = 0;
    while (grant != 2'b10 && n < 30) begin step(); n++; end
    chk("t5_gap_restart", n, 9);
    msg[0] = 16'h9999;
    send(1, 1, "t5_s1_word");
    wait_idle("t5_idle");

    // reset mid-message, then full re-send
    msg[0] = 16'hA001; msg[1] = 16'hA002; msg[2] = 16'hA003;
    hs_word(0, msg[0], 1'b0, "t6_w0");
    hs_word(0, msg[1], 1'b0, "t6_w1");
    put(0, 1'b1, msg[2], 1'b0);
    #1;
    chk("t6_pre_ready", s0_if.tready, 1);
    arst = 1'b1;
    #1;
    chk("t6_rst_en", en_tx, 0);
    chk("t6_rst_ready", s0_if.tready, 0);
    chk("t6_rst_valid", m_if.tvalid, 0);
    chk("t6_rst_grant", grant, 0);
    step(); step();
    arst = 1'b0;
    send(0, 3, "t6_resend");
    wait_idle("t6_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
